// File: rtl/mat_cache_fill.sv
// Row-cache fill engine: packs BEATW-element FP16 beats into WIDTH-element rows
// and writes each finished row to consecutive cache addresses from a base.
module mat_cache_fill #(
    parameter int WIDTH     = 128,
    parameter int CACHESIZE = 256,
    parameter int CACHEADDR = $clog2(CACHESIZE),
    parameter int FPSIZE    = 16,
    parameter int BEATW     = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [CACHEADDR-1:0]         base_addr,
    input  logic [CACHEADDR:0]           num_rows,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BEATW-1:0][FPSIZE-1:0] in_data,
    output logic                         wr_en,
    output logic [CACHEADDR-1:0]         wr_addr,
    output logic [WIDTH-1:0][FPSIZE-1:0] wr_data,
    output logic                         busy,
    output logic                         done
);
    localparam int BPR = WIDTH / BEATW;
    localparam int BCW = (BPR > 1) ? $clog2(BPR) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BPR - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    state_t state, state_next;

    logic [CACHEADDR-1:0]               base_q;
    logic [CACHEADDR:0]                 num_q;
    logic [CACHEADDR:0]                 row_cnt;
    logic [CACHEADDR:0]                 row_cnt_inc;
    logic [BCW-1:0]                     beat_cnt;
    logic [WIDTH-BEATW-1:0][FPSIZE-1:0] row_buf;
    logic                               handshake;
    logic                               last_beat;

    // Ready is a pure function of state, so the handshake is derived from state
    // directly rather than from in_ready to keep the FSM free of comb loops.
    assign handshake   = in_valid && (state == FILL);
    assign last_beat   = handshake && (beat_cnt == LAST_BEAT);
    assign row_cnt_inc = row_cnt + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (num_rows == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_en      = 1'b1;
                state_next = (row_cnt_inc == num_q) ? DONE : FILL;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The row buffer holds only the first BPR-1 beats; the final beat is merged
    // straight into wr_data so the output register updates once per row.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q   <= '0;
            num_q    <= '0;
            row_cnt  <= '0;
            beat_cnt <= '0;
            row_buf  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (num_rows != '0)) begin
                        base_q   <= base_addr;
                        num_q    <= num_rows;
                        beat_cnt <= '0;
                        row_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (handshake) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            wr_addr  <= base_q + row_cnt[CACHEADDR-1:0];
                            wr_data  <= {in_data, row_buf};
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            for (int unsigned k = 0; k < BPR - 1; k++) begin
                                if (beat_cnt == BCW'(k)) begin
                                    row_buf[k*BEATW +: BEATW] <= in_data;
                                end
                            end
                        end
                    end
                end
                WRITE: begin
                    row_cnt <= row_cnt_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_cache_fill.sv
// Bench for mat_cache_fill: random beats and valid gaps checked cycle by cycle
// against a row-level model built from accepted beats and expected write order.
`timescale 1ns/1ps
module tb_mat_cache_fill;
    localparam int WIDTH     = 128;
    localparam int CACHESIZE = 256;
    localparam int CACHEADDR = 8;
    localparam int FPSIZE    = 16;
    localparam int BEATW     = 8;
    localparam int BPR       = WIDTH / BEATW;
    localparam int NRW       = CACHEADDR + 1;
    localparam int MAX_CYC   = 20000;

    typedef logic [BEATW-1:0][FPSIZE-1:0] beat_t;
    typedef logic [WIDTH-1:0][FPSIZE-1:0] row_t;

    logic                 clock;
    logic                 reset_n;
    logic                 start;
    logic [CACHEADDR-1:0] base_addr;
    logic [NRW-1:0]       num_rows;
    logic                 in_valid;
    logic                 in_ready;
    beat_t                in_data;
    logic                 wr_en;
    logic [CACHEADDR-1:0] wr_addr;
    row_t                 wr_data;
    logic                 busy;
    logic                 done;

    int                   errors = 0;
    int                   checks = 0;
    logic [CACHEADDR-1:0] hold_addr;
    row_t                 hold_row;

    mat_cache_fill #(
        .WIDTH(WIDTH),
        .CACHESIZE(CACHESIZE),
        .CACHEADDR(CACHEADDR),
        .FPSIZE(FPSIZE),
        .BEATW(BEATW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .base_addr(base_addr),
        .num_rows(num_rows),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input row_t obs, input row_t exp);
        int first;
        checks++;
        assert (obs === exp) else begin
            errors++;
            first = 0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (obs[i] !== exp[i]) first = i;
            end
            $error("FAIL %s elem %0d observed=%h expected=%h", tag, first, obs[first], exp[first]);
        end
    endtask

    // Model: a row completes after BPR accepted beats, its write appears the next
    // cycle (no beat taken then), done follows the last write, busy spans the fill.
    task automatic run_fill(input int base, input int nrows, input int prob,
                            input int mid_start, input bit seq_data);
        beat_t acc_q[$];
        beat_t cur_beat;
        row_t  pend_row;
        int    pend_addr = 0;
        bit    have_beat = 1'b0;
        bit    active;
        bit    exp_wr = 1'b0;
        bit    exp_done;
        bit    next_wr;
        bit    next_done;
        bit    accept;
        bit    exp_ready;
        bit    finished = 1'b0;
        int    rows = 0;
        int    in_row = 0;
        int    cyc = 0;
        int    beat_idx = 0;
        int    nwr = 0;
        int    last_wr = -1;

        start     = 1'b1;
        base_addr = CACHEADDR'(base);
        num_rows  = NRW'(nrows);
        in_valid  = 1'b0;
        @(posedge clock); #1;
        start    = 1'b0;
        active   = (nrows != 0);
        exp_done = (nrows == 0);
        pend_row = '0;

        while (!finished && cyc < MAX_CYC) begin
            exp_ready = active && !exp_wr;
            if (exp_wr) begin
                hold_addr = CACHEADDR'(pend_addr);
                hold_row  = pend_row;
                nwr++;
                if (prob == 100 && last_wr >= 0) chk("wr_gap", cyc - last_wr, BPR + 1);
                last_wr = cyc;
            end
            chk("in_ready", in_ready, exp_ready);
            chk("wr_en", wr_en, exp_wr);
            chk("done", done, exp_done);
            chk("busy", busy, active || exp_done);
            chk("wr_addr", wr_addr, hold_addr);
            chk_row("wr_data", wr_data, hold_row);

            start     = (cyc == mid_start);
            base_addr = CACHEADDR'($urandom);
            num_rows  = NRW'($urandom_range(1, CACHESIZE));
            if (!have_beat) begin
                for (int j = 0; j < BEATW; j++) begin
                    cur_beat[j] = seq_data ? FPSIZE'(beat_idx * BEATW + j) : FPSIZE'($urandom);
                end
                have_beat = 1'b1;
            end
            in_valid = ($urandom_range(0, 99) < prob);
            in_data  = in_valid ? cur_beat : beat_t'({$urandom, $urandom, $urandom, $urandom});

            accept    = in_valid && exp_ready;
            next_wr   = 1'b0;
            next_done = 1'b0;
            if (exp_wr) begin
                rows++;
                if (rows == nrows) begin
                    active    = 1'b0;
                    next_done = 1'b1;
                end
            end
            if (accept) begin
                acc_q.push_back(cur_beat);
                have_beat = 1'b0;
                beat_idx++;
                in_row++;
                if (in_row == BPR) begin
                    for (int k = 0; k < BPR; k++) begin
                        for (int j = 0; j < BEATW; j++) pend_row[k*BEATW + j] = acc_q[k][j];
                    end
                    acc_q.delete();
                    in_row    = 0;
                    next_wr   = 1'b1;
                    pend_addr = (base + rows) % CACHESIZE;
                end
            end
            finished = exp_done;
            @(posedge clock); #1;
            cyc++;
            exp_wr   = next_wr;
            exp_done = next_done;
        end

        chk("fill_finished", finished, 1);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_wr_en", wr_en, 0);
        chk("idle_ready", in_ready, 0);
        chk("n_writes", nwr, nrows);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk_row({tag, "_wr_data"}, wr_data, '0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        hold_addr = '0;
        hold_row  = '0;
        #2;
        chk_reset_values("por");
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // single row, element i carries value i
        run_fill(5, 1, 100, -1, 1'b1);
        for (int i = 0; i < WIDTH; i++) chk("single_elem", wr_data[i], i);

        // address wrap past the top of the cache
        run_fill(254, 4, 100, -1, 1'b0);

        // backpressure with ignored mid-fill starts
        run_fill(int'($urandom_range(0, CACHESIZE - 1)), 2, 60, 10, 1'b0);
        run_fill(int'($urandom_range(0, CACHESIZE - 1)), 2, 35, 25, 1'b0);

        // zero rows
        run_fill(17, 0, 100, -1, 1'b0);

        // reset after 7 beats of row 0
        start     = 1'b1;
        base_addr = 8'd3;
        num_rows  = 9'd1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            chk("rst_pre_ready", in_ready, 1);
            chk("rst_pre_wr_en", wr_en, 0);
            in_valid = 1'b1;
            in_data  = beat_t'({$urandom, $urandom, $urandom, $urandom});
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values("midrow");
        hold_addr = '0;
        hold_row  = '0;
        @(posedge clock); #1;
        chk_reset_values("midrow_held");
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_fill(77, 1, 100, -1, 1'b0);

        // every cache row once
        run_fill(0, CACHESIZE, 100, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
